// File: rtl/alu_stack_sequencer.sv
// alu_stack_sequencer: operand-stack controller that sequences an external combinational ALU.
// Optional sticky ALU overflow flag enabled by defining ALU_OVF_STICKY_EN.
module alu_stack_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_kind,
  input  logic [3:0]       cmd_oper,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [3:0]       alu_oper,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_overflow,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             done,
  output logic             err_underflow,
  output logic             err_full,
  output logic             err_badop,
  input  logic             err_clr,
  output logic             ovf_flag
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_B, EXEC, WRITE, FAULT} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] stk [DEPTH];
  logic [WIDTH-1:0] ra, res;
  logic [3:0] op_q;
  logic un_q, alu_q, acc, un, bad, full, short_ops, set_u, set_f, set_b;
  logic [AW-1:0] ia, ib;
  assign acc = cmd_valid && cmd_ready;
  assign un = cmd_oper == 4'd8;
  assign bad = cmd_kind == 2'd3 || (cmd_kind == 2'd1 && cmd_oper >= 4'd10);
  assign full = depth == DW'(DEPTH);
  assign short_ops = depth < (un ? DW'(1) : DW'(2));
  assign set_b = acc && bad;
  assign set_f = acc && cmd_kind == 2'd0 && full;
  assign set_u = acc && !bad && ((cmd_kind == 2'd2 && depth == '0) || (cmd_kind == 2'd1 && short_ops));
  assign ia = AW'(depth - DW'(1));
  assign ib = AW'(depth - DW'(2));
  assign cmd_ready = state == IDLE;
  assign done = state == WRITE || state == FAULT;
  assign top = depth == '0 ? '0 : stk[ia];
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (acc) nxt = (set_b || set_f || set_u) ? FAULT : cmd_kind == 2'd1 ? FETCH_A : WRITE;
      FETCH_A: nxt = un_q ? EXEC : FETCH_B;
      FETCH_B: nxt = EXEC;
      EXEC:    nxt = WRITE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      depth <= '0;
      alu_oper <= '0;
      alu_a <= '0;
      alu_b <= '0;
      err_underflow <= 1'b0;
      err_full <= 1'b0;
      err_badop <= 1'b0;
    end else begin
      err_underflow <= set_u || (err_underflow && !err_clr);
      err_full <= set_f || (err_full && !err_clr);
      err_badop <= set_b || (err_badop && !err_clr);
      if (acc) begin
        op_q <= cmd_oper;
        un_q <= un;
        alu_q <= cmd_kind == 2'd1;
      end
      if (acc && cmd_kind == 2'd0 && !full) begin
        stk[AW'(depth)] <= cmd_data;
        depth <= depth + DW'(1);
      end
      if (acc && cmd_kind == 2'd2 && depth != '0) depth <= depth - DW'(1);
      if (state == FETCH_A) begin
        ra <= stk[ia];
        if (un_q) begin
          alu_oper <= op_q;
          alu_a <= stk[ia];
          alu_b <= '0;
        end
      end
      if (state == FETCH_B) begin
        alu_oper <= op_q;
        alu_a <= ra;
        alu_b <= stk[ib];
      end
      if (state == EXEC) res <= alu_out;
      // Operands are overwritten in place: the result lands in the lowest consumed slot
      if (state == WRITE && alu_q) begin
        stk[un_q ? ia : ib] <= res;
        depth <= un_q ? depth : depth - DW'(1);
      end
    end
  end
`ifdef ALU_OVF_STICKY_EN
  always_ff @(posedge clk)
    ovf_flag <= !reset && ((state == EXEC && alu_overflow && op_q < 4'd2) || (ovf_flag && !err_clr));
`else
  logic unused;
  assign unused = alu_overflow;
  assign ovf_flag = 1'b0;
`endif
endmodule

// File: tb/tb_alu_stack_sequencer.sv
// tb_alu_stack_sequencer: directed bench with a queue-based stack model and an ALU stand-in.
module tb_alu_stack_sequencer;
  localparam int D = 8;
  logic clk = 0, reset = 1, cmd_valid = 0, err_clr = 0;
  logic [1:0] cmd_kind = 0;
  logic [3:0] cmd_oper = 0, alu_oper;
  logic [15:0] cmd_data = 0, alu_a, alu_b, alu_out, top;
  logic [3:0] depth;
  logic cmd_ready, alu_overflow, done, err_underflow, err_full, err_badop, ovf_flag;
  alu_stack_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_oper(cmd_oper), .cmd_data(cmd_data),
    .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .alu_overflow(alu_overflow), .top(top), .depth(depth), .done(done),
    .err_underflow(err_underflow), .err_full(err_full), .err_badop(err_badop),
    .err_clr(err_clr), .ovf_flag(ovf_flag)
  );
  always #5 clk = ~clk;
  // External ALU: {overflow, result}; overflow is the unsigned carry/borrow of add/sub
  function automatic logic [16:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'd0: return {1'b0, b} + {1'b0, a};
      4'd1: return {b < a, b - a};
      4'd2: return {1'b0, b & a};
      4'd3: return {1'b0, b | a};
      4'd4: return {1'b0, b ^ a};
      4'd5: return {1'b0, a};
      4'd6: return {1'b0, b};
      4'd7: return {1'b0, 15'd0, a == b};
      4'd8: return {1'b0, 15'd0, a == 16'd0};
      4'd9: return {1'b0, 15'd0, b < a};
      default: return 17'd0;
    endcase
  endfunction
  assign {alu_overflow, alu_out} = alu_f(alu_oper, alu_a, alu_b);
  int errs = 0, checks = 0;
  bit chk_en = 0;
  logic [15:0] mq[$];
  bit mu = 0, mf = 0, mb = 0, mo = 0;
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (chk_en && !reset && cmd_ready) begin
      check("depth", 32'(depth), 32'(mq.size()));
      check("top", 32'(top), mq.size() != 0 ? 32'(mq[$]) : 32'd0);
      check("err_underflow", 32'(err_underflow), 32'(mu));
      check("err_full", 32'(err_full), 32'(mf));
      check("err_badop", 32'(err_badop), 32'(mb));
      check("ovf_flag", 32'(ovf_flag), 32'(mo));
      check("done_idle", 32'(done), 32'd0);
    end
  task automatic issue(input logic [1:0] k, input logic [3:0] op, input logic [15:0] d, input bit clr = 0);
    logic [15:0] nq[$];
    logic [15:0] a, b, r;
    bit nu, nf, nb, no, o, is_alu, un;
    int lat, need, n, cnt;
    nq = mq;
    {nu, nf, nb, no} = clr ? 4'b0 : {mu, mf, mb, mo};
    un = op == 4'd8;
    is_alu = 0;
    lat = 1;
    a = 0;
    b = 0;
    if (k == 2'd3 || (k == 2'd1 && op >= 4'd10)) nb = 1;
    else if (k == 2'd0) begin
      if (nq.size() == D) nf = 1;
      else nq.push_back(d);
    end else if (k == 2'd2) begin
      if (nq.size() == 0) nu = 1;
      else void'(nq.pop_back());
    end else begin
      need = un ? 1 : 2;
      if (nq.size() < need) nu = 1;
      else begin
        a = nq.pop_back();
        if (!un) b = nq.pop_back();
        {o, r} = alu_f(op, a, b);
`ifdef ALU_OVF_STICKY_EN
        if (op < 4'd2 && o) no = 1;
`endif
        nq.push_back(r);
        lat = need + 2;
        is_alu = 1;
      end
    end
    cnt = 0;
    while (!cmd_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    cmd_valid = 1;
    cmd_kind = k;
    cmd_oper = op;
    cmd_data = d;
    err_clr = clr;
    @(posedge clk);
    #1 cmd_valid = 0;
    err_clr = 0;
    for (n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (is_alu && n == lat - 1) begin
        check("exec_oper", 32'(alu_oper), 32'(op));
        check("exec_a", 32'(alu_a), 32'(a));
        if (!un) check("exec_b", 32'(alu_b), 32'(b));
      end
      if (done) break;
    end
    check("latency", n, lat);
    mq = nq;
    {mu, mf, mb, mo} = {nu, nf, nb, no};
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
  endtask
  task automatic clear_flags();
    err_clr = 1;
    @(posedge clk);
    #1 err_clr = 0;
    {mu, mf, mb, mo} = 4'b0;
    @(negedge clk);
  endtask
  task automatic drain();
    while (mq.size() != 0) issue(2, 0, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_done", 32'(done), 0);
    check("rst_alu", {alu_oper, alu_a, alu_b[11:0]}, 0);
    check("rst_depth_top", {depth, top}, 0);
    reset = 0;
    chk_en = 1;
    @(negedge clk);
    issue(0, 0, 16'h0006);
    issue(0, 0, 16'h0009);
    issue(1, 0, 0);
    check("t1_top", 32'(top), 32'h000F);
    check("t1_depth", 32'(depth), 1);
    drain();
    issue(0, 0, 16'hDEAD);
    issue(0, 0, 16'hBEEF);
    issue(1, 1, 0);
    check("t2_sub", 32'(top), 32'h1FBE);
    issue(0, 0, 16'hDEAD);
    issue(0, 0, 16'hBEEF);
    issue(1, 9, 0);
    check("t2_lt", 32'(top), 32'h0000);
    check("t2_depth", 32'(depth), 2);
    drain();
    issue(0, 0, 16'h0005);
    issue(1, 2, 0);
    check("t3_under", 32'(err_underflow), 1);
    check("t3_top", {depth, top}, {4'd1, 16'h0005});
    issue(1, 13, 0);
    check("t3_badop", 32'(err_badop), 1);
    clear_flags();
    check("t3_clr", {err_underflow, err_badop}, 0);
    drain();
    issue(2, 0, 0);
    issue(1, 12, 0);
    issue(3, 0, 0);
    check("badop_prio", {err_badop, err_underflow}, 2'b11);
    clear_flags();
    issue(1, 12, 0);
    check("badop_only", {err_badop, err_underflow}, 2'b10);
    for (int i = 1; i <= 9; i++) issue(0, 0, 16'(i), i == 9);
    check("t4_full", {err_full, err_badop}, 2'b10);
    check("t4_state", {depth, top}, {4'd8, 16'd8});
    issue(1, 4, 0);
    check("t4_xor", 32'(top), 32'h000F);
    issue(1, 6, 0);
    issue(1, 7, 0);
    issue(1, 3, 0);
    issue(1, 5, 0);
    issue(1, 2, 0);
    clear_flags();
    drain();
    issue(0, 0, 16'h0000);
    issue(1, 8, 0);
    check("t5_eqz", {depth, top}, {4'd1, 16'h0001});
    drain();
    issue(0, 0, 16'hFFFF);
    issue(0, 0, 16'h0001);
    issue(1, 0, 0);
    check("t6_wrap", 32'(top), 0);
`ifdef ALU_OVF_STICKY_EN
    check("t6_ovf", 32'(ovf_flag), 1);
`else
    check("t6_ovf", 32'(ovf_flag), 0);
`endif
    clear_flags();
    issue(0, 0, 16'h0003);
    issue(0, 0, 16'h0004);
    cmd_valid = 1;
    cmd_kind = 1;
    cmd_oper = 0;
    @(posedge clk);
    #1 cmd_valid = 0;
    repeat (3) @(negedge clk);
    check("exec_ab", {alu_a, alu_b}, {16'h0004, 16'h0003});
    reset = 1;
    mq.delete();
    {mu, mf, mb, mo} = 4'b0;
    @(negedge clk);
    check("rexec_depth", 32'(depth), 0);
    check("rexec_ready", 32'(cmd_ready), 1);
    check("rexec_done", 32'(done), 0);
    check("rexec_alu", 32'(alu_a), 0);
    reset = 0;
    @(negedge clk);
    check("rexec_nodone", 32'(done), 0);
    issue(0, 0, 16'h0055);
    check("post_reset", {depth, top}, {4'd1, 16'h0055});
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
